half_adder_top: RTL and testbench
=================================

# half_adder_top

Registered, flow-controlled half-adder stage for the 4-bit ALU datapath. It computes the bitwise half-add of two operand vectors, with Sum = A XOR B and Cout = A AND B per bit. Results are held in a 2-entry output queue behind a valid/ready handshake, so that upstream and downstream stages can stall independently. One clock; no arithmetic carries ripple between bit positions.

## Interface
Parameters:
- WIDTH, default 1: operand width in bits; legal range 1..32.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low. Clock and reset are fixed as one clock with asynchronous active-low reset.
- in_valid  input  1  A/B carry a valid operand pair this cycle.
- in_ready  output  1  stage can accept an operand pair this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- out_valid  output  1  Sum/Cout carry a valid result.
- out_ready  input  1  downstream accepts the result this cycle.
- Sum  output  WIDTH  per-bit sum, A XOR B.
- Cout  output  WIDTH  per-bit carry, A AND B.

## Operation
- Push: a push occurs when in_valid and in_ready are both 1 at a rising edge. It writes {A^B, A&B} into the queue tail.
- Pop: a pop occurs when out_valid and out_ready are both 1 at a rising edge. It removes the queue head.
- Queue: 2 entries, strict FIFO order, with an occupancy count of 0..2.
- in_ready = (count != 2), purely from registered state. There is no combinational path from out_ready to in_ready.
- out_valid = (count != 0).
- Sum/Cout always show the head entry when out_valid = 1, and are forced to all-zero when out_valid = 0.
- Simultaneous push and pop:
  - count = 1: head leaves, new entry becomes head next cycle, count stays 1.
  - count = 2: push is impossible because in_ready = 0; pop only.
- A and B are ignored when no push occurs. X on A/B without in_valid must not corrupt state.
- Per-bit results are independent; bit i depends only on A[i] and B[i].

## Timing
- Reset (rst_n low, asynchronous):
  - count = 0 and queue cleared immediately, without waiting for clk.
  - out_valid = 0, Sum = 0, Cout = 0, in_ready = 1.
- While rst_n is low, no push or pop takes effect regardless of handshakes.
- Reset mid-operation discards all queued entries; nothing is emitted after release.
- First push is accepted on the first rising edge after rst_n is released.
- Latency: a pushed pair appears on Sum/Cout with out_valid = 1 on the cycle after the push edge, if the queue was empty. Otherwise it appears after all older entries pop.
- Throughput: 1 result per cycle when out_ready is held at 1.
- Buffering: with out_ready = 0, exactly 2 pairs are absorbed before in_ready drops.
- in_ready rises the cycle after a pop from the full state.
- Output stability: while out_valid = 1 and out_ready = 0, Sum/Cout/out_valid must not change.

## Test plan
- Truth table, WIDTH=1, out_ready=1: push (A,B) = (0,0), (0,1), (1,0), (1,1) on consecutive cycles -> Sum/Cout = 0/0, 1/0, 1/0, 0/1, each one cycle after its push, out_valid high for 4 consecutive cycles.
- Vector, WIDTH=4: push A=1011, B=0110 -> Sum=1101, Cout=0010. Then push A=1111, B=1111 -> Sum=0000, Cout=1111.
- Backpressure, WIDTH=1, out_ready=0:
  - Push (1,1), then (1,0) -> in_ready=0 after the second push; a third in_valid is not accepted.
  - Raise out_ready -> results 0/1 then 1/0 in order; in_ready returns to 1 the cycle after the first pop.
- Simultaneous push/pop at count=1 -> count stays 1 and output order is preserved across 8 back-to-back pairs with no bubbles.
- Reset mid-operation: queue holds 2 entries, then rst_n is pulsed low between clock edges -> out_valid, Sum and Cout go to 0 immediately and in_ready goes to 1. No stale result appears after release.
- Idle/X robustness: in_valid=0 with A/B = X or toggling -> out_valid stays 0 and Sum/Cout stay 0.

Source files
------------

// File: rtl/half_adder_top.sv
// Registered half-adder stage: per-bit {A^B, A&B} results held in a 2-entry
// FIFO behind valid/ready handshakes on both sides.
module half_adder_top #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic [WIDTH-1:0] Cout
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  occ_e             occ_q, occ_d;
  logic [WIDTH-1:0] sum0_q, sum0_d, cout0_q, cout0_d;
  logic [WIDTH-1:0] sum1_q, sum1_d, cout1_q, cout1_d;
  logic             push, pop;

  // Both handshake outputs depend on registered occupancy only.
  assign in_ready  = (occ_q != OCC_FULL);
  assign out_valid = (occ_q != OCC_EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    occ_d   = occ_q;
    sum0_d  = sum0_q;
    cout0_d = cout0_q;
    sum1_d  = sum1_q;
    cout1_d = cout1_q;
    case (occ_q)
      OCC_EMPTY: begin
        if (push) begin
          sum0_d  = A ^ B;
          cout0_d = A & B;
          occ_d   = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (push && pop) begin
          sum0_d  = A ^ B;
          cout0_d = A & B;
        end else if (push) begin
          sum1_d  = A ^ B;
          cout1_d = A & B;
          occ_d   = OCC_FULL;
        end else if (pop) begin
          occ_d   = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (pop) begin
          sum0_d  = sum1_q;
          cout0_d = cout1_q;
          occ_d   = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q   <= OCC_EMPTY;
      sum0_q  <= '0;
      cout0_q <= '0;
      sum1_q  <= '0;
      cout1_q <= '0;
    end else begin
      occ_q   <= occ_d;
      sum0_q  <= sum0_d;
      cout0_q <= cout0_d;
      sum1_q  <= sum1_d;
      cout1_q <= cout1_d;
    end
  end

  assign Sum  = out_valid ? sum0_q  : '0;
  assign Cout = out_valid ? cout0_q : '0;

endmodule

// File: tb/tb_half_adder_top.sv
// Scoreboard bench for half_adder_top: a WIDTH=1 and a WIDTH=4 instance,
// directed vectors with hand-computed results, negedge monitors pop and compare.
module tb_half_adder_top;

  typedef struct packed {
    logic [3:0] s;
    logic [3:0] c;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       v1 = 1'b0, o1 = 1'b1;
  logic [0:0] a1 = '0, b1 = '0;
  logic       r1, ov1;
  logic [0:0] s1, c1;

  logic       v4 = 1'b0, o4 = 1'b1;
  logic [3:0] a4 = '0, b4 = '0;
  logic       r4, ov4;
  logic [3:0] s4, c4;

  exp_t q1[$];
  exp_t q4[$];

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  half_adder_top #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1), .A(a1), .B(b1),
    .out_valid(ov1), .out_ready(o1), .Sum(s1), .Cout(c1)
  );

  half_adder_top #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4), .A(a4), .B(b4),
    .out_valid(ov4), .out_ready(o4), .Sum(s4), .Cout(c4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("u1.out_valid", 32'(ov1), 32'(q1.size() != 0));
      chk("u1.in_ready", 32'(r1), 32'(q1.size() < 2));
      if (ov1 && q1.size() != 0) begin
        chk("u1.Sum", 32'(s1), 32'(q1[0].s));
        chk("u1.Cout", 32'(c1), 32'(q1[0].c));
        if (o1) void'(q1.pop_front());
      end else if (!ov1) begin
        chk("u1.Sum idle", 32'(s1), 32'd0);
        chk("u1.Cout idle", 32'(c1), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("u4.out_valid", 32'(ov4), 32'(q4.size() != 0));
      chk("u4.in_ready", 32'(r4), 32'(q4.size() < 2));
      if (ov4 && q4.size() != 0) begin
        chk("u4.Sum", 32'(s4), 32'(q4[0].s));
        chk("u4.Cout", 32'(c4), 32'(q4[0].c));
        if (o4) void'(q4.pop_front());
      end else if (!ov4) begin
        chk("u4.Sum idle", 32'(s4), 32'd0);
        chk("u4.Cout idle", 32'(c4), 32'd0);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the pair is accepted.
  task automatic send1(input logic a, input logic b, input logic es, input logic ec);
    logic rdy;
    bit   done = 0;
    a1 = a; b1 = b; v1 = 1'b1;
    for (int unsigned t = 0; t < 40 && !done; t++) begin
      @(negedge clk); rdy = r1;
      @(posedge clk);
      if (rdy) begin
        q1.push_back('{s: {3'b0, es}, c: {3'b0, ec}});
        done = 1;
      end
    end
    if (!done) chk("u1.accept timeout", 32'd0, 32'd1);
    #1 v1 = 1'b0;
  endtask

  task automatic send4(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] es, input logic [3:0] ec);
    logic rdy;
    bit   done = 0;
    a4 = a; b4 = b; v4 = 1'b1;
    for (int unsigned t = 0; t < 40 && !done; t++) begin
      @(negedge clk); rdy = r4;
      @(posedge clk);
      if (rdy) begin
        q4.push_back('{s: es, c: ec});
        done = 1;
      end
    end
    if (!done) chk("u4.accept timeout", 32'd0, 32'd1);
    #1 v4 = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // {A, B, Sum, Cout} for the 1-bit truth table
  logic [3:0] tt [4] = '{4'b0000, 4'b0110, 4'b1010, 4'b1101};
  // 1-bit back-to-back stream {A, B, Sum, Cout}
  logic [3:0] st [8] = '{4'b1101, 4'b0110, 4'b0000, 4'b1010,
                         4'b1101, 4'b1010, 4'b0110, 4'b0000};
  // 4-bit vectors {A, B, Sum, Cout}
  logic [15:0] v4tab [4] = '{16'b1011_0110_1101_0010, 16'b1111_1111_0000_1111,
                             16'b0101_0011_0110_0001, 16'b1000_0000_1000_0000};

  initial begin
    int c0;
    logic [3:0]  e;
    logic [15:0] w;

    #3;
    chk("rst u1.out_valid", 32'(ov1), 32'd0);
    chk("rst u1.in_ready", 32'(r1), 32'd1);
    chk("rst u1.Sum/Cout", 32'({s1, c1}), 32'd0);
    chk("rst u4.out_valid", 32'(ov4), 32'd0);
    chk("rst u4.Sum/Cout", 32'({s4, c4}), 32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // truth table, one result per cycle
    for (int i = 0; i < 4; i++) begin
      e = tt[i];
      send1(e[3], e[2], e[1], e[0]);
    end
    idle(3);

    // 4-bit vectors
    for (int i = 0; i < 4; i++) begin
      w = v4tab[i];
      send4(w[15:12], w[11:8], w[7:4], w[3:0]);
    end
    idle(3);

    // backpressure: two absorbed, third held off
    o1 = 1'b0;
    send1(1'b1, 1'b1, 1'b0, 1'b1);
    send1(1'b1, 1'b0, 1'b1, 1'b0);
    a1 = 1'b0; b1 = 1'b1; v1 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("u1.full in_ready", 32'(r1), 32'd0);
      @(posedge clk); #1;
    end
    v1 = 1'b0;
    o1 = 1'b1;
    idle(4);

    // simultaneous push/pop at count=1, no bubbles
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      e = st[i];
      send1(e[3], e[2], e[1], e[0]);
    end
    chk("u1.stream cycles", 32'(cyc - c0), 32'd8);
    idle(3);

    // reset mid-operation with both queues full
    o1 = 1'b0; o4 = 1'b0;
    send1(1'b1, 1'b1, 1'b0, 1'b1);
    send1(1'b0, 1'b1, 1'b1, 1'b0);
    send4(4'b1100, 4'b1010, 4'b0110, 4'b1000);
    send4(4'b0001, 4'b0001, 4'b0000, 4'b0001);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid-rst u1.out_valid", 32'(ov1), 32'd0);
    chk("mid-rst u1.in_ready", 32'(r1), 32'd1);
    chk("mid-rst u1.Sum/Cout", 32'({s1, c1}), 32'd0);
    chk("mid-rst u4.out_valid", 32'(ov4), 32'd0);
    chk("mid-rst u4.in_ready", 32'(r4), 32'd1);
    chk("mid-rst u4.Sum/Cout", 32'({s4, c4}), 32'd0);
    q1.delete(); q4.delete();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    o1 = 1'b1; o4 = 1'b1;
    idle(4);

    // idle inputs with garbage operands
    a1 = 'x; b1 = 'x; a4 = 'x; b4 = 'x;
    idle(1);
    for (int i = 0; i < 6; i++) begin
      a1 = 1'($urandom); b1 = 1'($urandom);
      a4 = 4'($urandom); b4 = 4'($urandom);
      idle(1);
    end

    for (int unsigned t = 0; t < 50 && (q1.size() != 0 || q4.size() != 0); t++) idle(1);
    chk("drain", 32'(q1.size() + q4.size()), 32'd0);
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
